addsub_pipe: RTL and testbench

Two-stage pipelined add/subtract unit that consumes the HCLA 4-bit carry-lookahead slices and their group generate/propagate outputs. Stage 1 registers the operands and the operation. Stage 2 forms the W-bit result through a second-level carry generator over the slice G/P signals, then registers the result and the N/Z/C/V flags. The unit sits between the register-file read ports and the writeback mux, with a valid/ready handshake on both sides.

---
 rtl/addsub_pipe.sv | 153 +++++++++++++++
 tb/tb_addsub_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe.sv
// addsub_pipe: two-stage pipelined W-bit add/subtract built from 4-bit lookahead slices.
// Optional signed saturation of the result is enabled by defining ADDSUB_SAT_EN.

module addsub_hcla4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_g,
    output logic       o_p
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic       w_c1;
    logic       w_c2;
    logic       w_c3;

    assign w_g  = i_a & i_b;
    assign w_p  = i_a ^ i_b;

    // Group G/P depend only on the operands so the second level can look ahead.
    assign o_g  = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign o_p  = &w_p;

    assign w_c1 = w_g[0] | (w_p[0] & i_cin);
    assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c3 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_sum = w_p ^ {w_c3, w_c2, w_c1, i_cin};
endmodule

module addsub_pipe #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         flag_n,
    output logic         flag_z,
    output logic         flag_c,
    output logic         flag_v
);
    localparam int unsigned NS = W / 4;

    logic         r_s1_valid;
    logic [W-1:0] r_s1_a;
    logic [W-1:0] r_s1_b;
    logic         r_s1_sub;

    logic         r_out_valid;
    logic [W-1:0] r_result;
    logic         r_flag_n;
    logic         r_flag_z;
    logic         r_flag_c;
    logic         r_flag_v;

    logic [W-1:0]  w_bx;
    logic [W-1:0]  w_sum;
    logic [W-1:0]  w_res;
    logic [NS-1:0] w_gg;
    logic [NS-1:0] w_gp;
    logic [NS:0]   w_c;
    logic          w_v;
    logic          w_s2_adv;
    logic          w_s1_adv;

    assign w_bx = r_s1_b ^ {W{r_s1_sub}};

    genvar k;
    for (k = 0; k < NS; k++) begin : g_slice
        addsub_hcla4 u_slice (
            .i_a   (r_s1_a[4*k +: 4]),
            .i_b   (w_bx[4*k +: 4]),
            .i_cin (w_c[k]),
            .o_sum (w_sum[4*k +: 4]),
            .o_g   (w_gg[k]),
            .o_p   (w_gp[k])
        );
    end

    // Second-level carry generator over the slice group G/P.
    always_comb begin
        w_c    = '0;
        w_c[0] = r_s1_sub;
        for (int unsigned i = 0; i < NS; i++) begin
            w_c[i+1] = w_gg[i] | (w_gp[i] & w_c[i]);
        end
    end

    assign w_v = (r_s1_a[W-1] == w_bx[W-1]) & (w_sum[W-1] != r_s1_a[W-1]);

`ifdef ADDSUB_SAT_EN
    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};
    assign w_res = w_v ? (r_s1_a[W-1] ? SAT_MIN : SAT_MAX) : w_sum;
`else
    assign w_res = w_sum;
`endif

    assign w_s2_adv = ~r_out_valid | out_ready;
    assign w_s1_adv = ~r_s1_valid | w_s2_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_sub    <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flag_n    <= 1'b0;
            r_flag_z    <= 1'b1;
            r_flag_c    <= 1'b0;
            r_flag_v    <= 1'b0;
        end else begin
            if (w_s2_adv) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_result <= w_res;
                    r_flag_n <= w_res[W-1];
                    r_flag_z <= (w_res == '0);
                    r_flag_c <= w_c[NS];
                    r_flag_v <= w_v;
                end
            end
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_a   <= a;
                    r_s1_b   <= b;
                    r_s1_sub <= sub;
                end
            end
        end
    end

    assign in_ready  = w_s1_adv;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flag_n    = r_flag_n;
    assign flag_z    = r_flag_z;
    assign flag_c    = r_flag_c;
    assign flag_v    = r_flag_v;
endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed vectors plus a queue-based arithmetic model checked every cycle.
// Expected saturation behaviour follows ADDSUB_SAT_EN when it is defined for the build.

module tb_addsub_pipe;
    localparam int unsigned W = 16;

    typedef struct packed {
        logic [W-1:0] res;
        logic         n;
        logic         z;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         flag_n;
    logic         flag_z;
    logic         flag_c;
    logic         flag_v;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    exp_t q[$];

    addsub_pipe #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_n    (flag_n),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Integer arithmetic on the signed/unsigned meaning of the operands.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t   e;
        longint ux, uy, ur, sx, sy, tr, smax, smin;
        ux   = longint'(x);
        uy   = longint'(y);
        sx   = x[W-1] ? ux - (longint'(1) << W) : ux;
        sy   = y[W-1] ? uy - (longint'(1) << W) : uy;
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
        tr   = s ? sx - sy : sx + sy;
        ur   = (s ? ux - uy : ux + uy) & ((longint'(1) << W) - 1);
        e.c  = s ? (ux >= uy) : ((ux + uy) >= (longint'(1) << W));
        e.v  = (tr > smax) || (tr < smin);
        e.res = W'(ur);
`ifdef ADDSUB_SAT_EN
        if (e.v) e.res = (tr > 0) ? W'(smax) : W'(smin);
`endif
        e.n  = e.res[W-1];
        e.z  = (e.res == '0);
        return e;
    endfunction

    // Compare process: occupancy, handshake, stall stability and in-order results.
    logic        prev_stall = 1'b0;
    logic [19:0] prev_out;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", 32'({result, flag_n, flag_z, flag_c, flag_v}), 32'(prev_out));
            check("in_ready_model", 32'(in_ready), 32'(!(q.size() == 2 && !out_ready)));
            if (q.size() == 0) check("out_valid_empty", 32'(out_valid), 32'(0));
            if (q.size() == 2) check("out_valid_full", 32'(out_valid), 32'(1));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_beat", 32'(1), 32'(0));
                end else begin
                    e = q.pop_front();
                    check("result", 32'({result, flag_n, flag_z, flag_c, flag_v}), 32'(e));
                    n_out++;
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, sub));
            prev_stall = out_valid && !out_ready;
            prev_out   = {result, flag_n, flag_z, flag_c, flag_v};
        end
    end

    task automatic send_check(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic s, input logic [W-1:0] er,
                              input logic en, input logic ez, input logic ec, input logic ev);
        int lat;
        @(posedge clk); #1;
        a = x; b = y; sub = s; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check({nm, "_in_ready"}, 32'(in_ready), 32'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({nm, "_latency"}, 32'(lat), 32'(2));
        check({nm, "_res"}, 32'(result), 32'(er));
        check({nm, "_nzcv"}, 32'({flag_n, flag_z, flag_c, flag_v}), 32'({en, ez, ec, ev}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] sa [8] = '{16'h0001, 16'h8000, 16'hFFFF, 16'h1234,
                                 16'h7FFF, 16'h0000, 16'hA5A5, 16'h0100};
        logic [W-1:0] sb [8] = '{16'h0002, 16'h0001, 16'h0001, 16'h1234,
                                 16'hFFFF, 16'h0001, 16'h5A5A, 16'h0200};
        logic         ss [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic         pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp_t         pin;
        int           i, cyc, n0, wait_cnt;
        logic         acc;

        // Junk inputs during reset must be ignored.
        rst = 1'b1; in_valid = 1'b1; a = 16'hDEAD; b = 16'hBEEF; sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rst_out_valid", 32'(out_valid), 32'(0));
            check("rst_in_ready", 32'(in_ready), 32'(1));
            check("rst_flags", 32'({result, flag_n, flag_z, flag_c, flag_v}), 32'({16'h0, 4'b0100}));
        end

        // Pin the model against hand-computed values.
        pin = model(16'h1234, 16'h4321, 1'b0);
        check("model_add", 32'(pin), 32'({16'h5555, 4'b0000}));
        pin = model(16'h0003, 16'h0005, 1'b1);
        check("model_sub", 32'(pin), 32'({16'hFFFE, 4'b1000}));

        send_check("add",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ADDSUB_SAT_EN
        send_check("ovf",   16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1);
        send_check("novf",  16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1);
`else
        send_check("ovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1);
        send_check("novf",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b1);
`endif
        send_check("subz",  16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
        send_check("subn",  16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0);
        send_check("wrap",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);

        // Back-to-back stream under out_ready pattern 1,0,0,1.
        @(posedge clk); #1;
        n0 = n_out; i = 0; cyc = 0;
        while (i < 8 && cyc < 200) begin
            in_valid = 1'b1; a = sa[i]; b = sb[i]; sub = ss[i];
            out_ready = pat[cyc % 4];
            cyc++;
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) i++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        wait_cnt = 0;
        while (q.size() != 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        @(negedge clk);
        check("stream_count", 32'(n_out - n0), 32'(8));
        check("stream_drained", 32'(q.size()), 32'(0));

        // Reset with two beats in flight.
        @(posedge clk); #1;
        in_valid = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        a = 16'h3333; b = 16'h4444;
        @(posedge clk); #1;
        rst = 1'b1; a = 16'h5555; b = 16'h6666;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_out_valid", 32'(out_valid), 32'(0));
        check("rst_mid_in_ready", 32'(in_ready), 32'(1));
        @(negedge clk);
        check("rst_mid_s1_empty", 32'(out_valid), 32'(0));
        send_check("post_rst", 16'h0F0F, 16'h0101, 1'b1, 16'h0E0E, 1'b0, 1'b0, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
